alu_bist: RTL and testbench



---
 rtl/alu_bist_pkg.sv | 35 +++
 rtl/bist_lfsr.sv | 22 ++
 rtl/alu_bist.sv | 106 ++++++++++
 tb/tb_alu_bist.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test.
// ALU operation encoding, BIST state encoding, LFSR taps and MISR polynomial.
package alu_bist_pkg;

    typedef logic [63:0] dword_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } aluop_t;

    localparam int ALU_NUM_OPS = 8;
    localparam int ALU_OP_W    = (ALU_NUM_OPS > 1) ? $clog2(ALU_NUM_OPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bist_state_t;

    localparam dword_t BIST_LFSR_TAPS = 64'hD800_0000_0000_0000;
    localparam dword_t BIST_MISR_POLY = 64'h0000_0000_0000_001B;

    // One MISR compaction step: shift with polynomial feedback, fold in result and zero flag.
    function automatic dword_t misr_step(dword_t sig, dword_t data, logic z);
        return {sig[62:0], 1'b0} ^ (sig[63] ? BIST_MISR_POLY : '0) ^ data ^ {63'b0, z};
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 64-bit Galois LFSR, right shifting, with synchronous reload to SEED.
// Latency: new state one cycle after en; load and reset both force SEED.
module bist_lfsr #(
    parameter logic [63:0] TAPS = 64'hD800_0000_0000_0000,
    parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    output logic [63:0] state
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= SEED;
        end else if (en) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : 64'd0);
        end
    end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test: drives LFSR operands through every ALU op, compacts results into a MISR.
// One vector per cycle while busy; start is ignored during a run, RST aborts to IDLE.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int          NUM_VECTORS = 256,
    parameter logic [63:0] SEED        = 64'h0000_0000_0000_0001
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [63:0] expected_sig,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [63:0] signature,
    output dword_t      porta,
    output dword_t      portb,
    output aluop_t      ALUOp,
    input  dword_t      aluout,
    input  logic        zero
);

    localparam int VEC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [VEC_W-1:0]    VEC_LAST = VEC_W'(NUM_VECTORS - 1);
    localparam logic [ALU_OP_W-1:0] OP_LAST  = ALU_OP_W'(ALU_NUM_OPS - 1);

    if (SEED == 64'd0) begin : g_seed_check
        $error("alu_bist: SEED must be nonzero or the LFSR locks up");
    end

    bist_state_t           state;
    bist_state_t           state_nxt;
    dword_t                sig;
    dword_t                lfsr;
    logic [VEC_W-1:0]      vec_cnt;
    logic [ALU_OP_W-1:0]   op_cnt;
    logic                  launch;
    logic                  last_vec;

    // A run can be launched from IDLE or DONE only; start inside RUN is dropped.
    assign launch   = start && (state != RUN);
    assign last_vec = (vec_cnt == VEC_LAST) && (op_cnt == OP_LAST);

    bist_lfsr #(
        .TAPS (BIST_LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (CLK),
        .rst   (RST),
        .load  (launch),
        .en    (busy),
        .state (lfsr)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_vec) state_nxt = DONE;
            DONE:    if (start)    state_nxt = RUN;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == RUN);
        done  = (state == DONE);
        porta = '0;
        portb = '0;
        ALUOp = aluop_t'(ALU_OP_W'(0));
        if (busy) begin
            porta = lfsr;
            portb = {lfsr[31:0], lfsr[63:32]};
            ALUOp = aluop_t'(op_cnt);
        end
    end

    assign signature = sig;
    assign pass      = done && (sig == expected_sig);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            sig     <= '0;
            vec_cnt <= '0;
            op_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                sig     <= '0;
                vec_cnt <= '0;
                op_cnt  <= '0;
            end else if (busy) begin
                sig <= misr_step(sig, aluout, zero);
                if (vec_cnt == VEC_LAST) begin
                    vec_cnt <= '0;
                    op_cnt  <= op_cnt + 1'b1;
                end else begin
                    vec_cnt <= vec_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist with a behavioural ALU stub and a whole-run signature model.
module tb_alu_bist;
    import alu_bist_pkg::*;

    localparam int NV    = 4;
    localparam int TOTAL = NV * ALU_NUM_OPS;
    localparam logic [63:0] TB_SEED = 64'h1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [63:0] expected_sig = '0;
    logic        busy, done, pass;
    logic [63:0] signature;
    dword_t      porta, portb, aluout;
    aluop_t      ALUOp;
    logic        zero;

    // 0 real ALU, 1 constant 1, 2 real ALU with bit5 fault, 3 random keyed hash
    int          mode = 0;
    dword_t      key = '0;
    dword_t      fault_a = '0;
    dword_t      exp_a [TOTAL];
    dword_t      golden;
    int          n_chk = 0;
    int          n_fail = 0;

    alu_bist #(.NUM_VECTORS(NV), .SEED(TB_SEED)) dut (
        .CLK(CLK), .RST(RST), .start(start), .expected_sig(expected_sig),
        .busy(busy), .done(done), .pass(pass), .signature(signature),
        .porta(porta), .portb(portb), .ALUOp(ALUOp), .aluout(aluout), .zero(zero)
    );

    always #5 CLK = ~CLK;

    function automatic dword_t alu_ref(aluop_t op, dword_t a, dword_t b);
        dword_t r;
        logic [5:0] sh;
        sh = b[5:0];
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            ALU_SLL: r = a << sh;
            ALU_SRL: r = a >> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic dword_t stub_out(int m, aluop_t op, dword_t a, dword_t b, dword_t k, dword_t fa);
        dword_t r;
        case (m)
            1:       r = 64'h1;
            2:       begin r = alu_ref(op, a, b); if (a == fa) r[5] = 1'b1; end
            3:       r = (a * k) ^ b;
            default: r = alu_ref(op, a, b);
        endcase
        return r;
    endfunction

    function automatic logic stub_zero(int m, dword_t r);
        if (m == 1) return 1'b0;
        if (m == 3) return r[7];
        return (r == 64'd0);
    endfunction

    always_comb begin
        aluout = stub_out(mode, ALUOp, porta, portb, key, fault_a);
        zero   = stub_zero(mode, stub_out(mode, ALUOp, porta, portb, key, fault_a));
    end

    // Whole-run reference: walk every vector in order and fold it into the signature.
    task automatic model_run(input int m, output dword_t s);
        dword_t l, a, b, o;
        aluop_t op;
        logic   z;
        l = TB_SEED;
        s = '0;
        for (int k = 0; k < TOTAL; k++) begin
            a  = l;
            b  = {a[31:0], a[63:32]};
            op = aluop_t'(3'(k / NV));
            exp_a[k] = a;
            o  = stub_out(m, op, a, b, key, fault_a);
            z  = stub_zero(m, o);
            s  = {s[62:0], 1'b0} ^ (s[63] ? 64'h1B : 64'h0) ^ o ^ {63'b0, z};
            l  = l[0] ? ((l >> 1) ^ 64'hD800_0000_0000_0000) : (l >> 1);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        int g;
        nbusy = 0;
        g = 0;
        while (done !== 1'b1 && g < 400) begin
            if (busy === 1'b1) nbusy++;
            tick();
            g++;
        end
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, g); end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        n_chk++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_chk++; if (pass !== 1'b0)       begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass); end
        n_chk++; if (signature !== 64'd0) begin n_fail++; $display("FAIL reset_sig: got %h want 0", signature); end
        n_chk++; if (porta !== 64'd0)     begin n_fail++; $display("FAIL reset_porta: got %h want 0", porta); end
        n_chk++; if (portb !== 64'd0)     begin n_fail++; $display("FAIL reset_portb: got %h want 0", portb); end
        n_chk++; if (ALUOp !== ALU_ADD)   begin n_fail++; $display("FAIL reset_aluop: got %0d want 0", ALUOp); end
        RST = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_pattern_misr();
        int     nb;
        dword_t s;
        mode = 1;
        model_run(1, s);
        start_pulse();
        n_chk++; if (busy !== 1'b1)                   begin n_fail++; $display("FAIL pat_busy: got %b want 1", busy); end
        n_chk++; if (porta !== 64'h1)                 begin n_fail++; $display("FAIL pat_a1: got %h want 1", porta); end
        n_chk++; if (portb !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL pat_b1: got %h want 0000000100000000", portb); end
        n_chk++; if (ALUOp !== ALU_ADD)               begin n_fail++; $display("FAIL pat_op1: got %0d want 0", ALUOp); end
        n_chk++; if (signature !== 64'd0)             begin n_fail++; $display("FAIL misr_0: got %h want 0", signature); end
        tick();
        n_chk++; if (porta !== 64'hD800_0000_0000_0000) begin n_fail++; $display("FAIL pat_a2: got %h want d800000000000000", porta); end
        n_chk++; if (portb !== 64'h0000_0000_D800_0000) begin n_fail++; $display("FAIL pat_b2: got %h want 00000000d8000000", portb); end
        n_chk++; if (signature !== 64'h1)             begin n_fail++; $display("FAIL misr_1: got %h want 1", signature); end
        tick();
        n_chk++; if (signature !== 64'h3)             begin n_fail++; $display("FAIL misr_2: got %h want 3", signature); end
        tick();
        n_chk++; if (signature !== 64'h7)             begin n_fail++; $display("FAIL misr_3: got %h want 7", signature); end
        wait_done(nb);
        n_chk++; if (nb !== TOTAL - 3)                begin n_fail++; $display("FAIL pat_len: got %0d want %0d", nb, TOTAL - 3); end
        n_chk++; if (signature !== s)                 begin n_fail++; $display("FAIL pat_sig: got %h want %h", signature, s); end
    endtask

    task automatic test_length_golden();
        int nb, g;
        aluop_t want_op;
        mode = 0;
        model_run(0, golden);
        start_pulse();
        nb = 0;
        g = 0;
        while (busy === 1'b1 && g < 400) begin
            want_op = aluop_t'(3'(nb / NV));
            n_chk++; if (ALUOp !== want_op) begin n_fail++; $display("FAIL len_op[%0d]: got %0d want %0d", nb, ALUOp, want_op); end
            nb++;
            tick();
            g++;
        end
        n_chk++; if (nb !== TOTAL)         begin n_fail++; $display("FAIL len_busy: got %0d cycles want %0d", nb, TOTAL); end
        n_chk++; if (done !== 1'b1)        begin n_fail++; $display("FAIL len_done_next: got %b want 1", done); end
        n_chk++; if (signature !== golden) begin n_fail++; $display("FAIL golden_sig: got %h want %h", signature, golden); end
        n_chk++; if (porta !== 64'd0)      begin n_fail++; $display("FAIL done_porta: got %h want 0", porta); end
    endtask

    task automatic test_pass_fail();
        expected_sig = golden;
        #1;
        n_chk++; if (pass !== 1'b1) begin n_fail++; $display("FAIL pass_match: got %b want 1", pass); end
        expected_sig = golden ^ 64'h1;
        #1;
        n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL pass_flip: got %b want 0", pass); end
    endtask

    task automatic test_fault();
        int     nb, fk;
        dword_t fsig, r, b;
        fk = 0;
        for (int t = 0; t < 100; t++) begin
            fk = $urandom_range(TOTAL - 1);
            b  = {exp_a[fk][31:0], exp_a[fk][63:32]};
            r  = alu_ref(aluop_t'(3'(fk / NV)), exp_a[fk], b);
            if (r[5] == 1'b0) break;
        end
        fault_a = exp_a[fk];
        model_run(2, fsig);
        mode = 2;
        expected_sig = golden;
        start_pulse();
        n_chk++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rerun_flags: done=%b busy=%b want 0/1", done, busy); end
        n_chk++; if (signature !== 64'd0)            begin n_fail++; $display("FAIL rerun_sig0: got %h want 0", signature); end
        wait_done(nb);
        n_chk++; if (signature !== fsig)             begin n_fail++; $display("FAIL fault_sig: got %h want %h", signature, fsig); end
        n_chk++; if (pass !== 1'b0)                  begin n_fail++; $display("FAIL fault_pass: got %b want 0", pass); end
    endtask

    task automatic test_restart();
        int nb;
        mode = 0;
        expected_sig = golden;
        start_pulse();
        wait_done(nb);
        n_chk++; if (signature !== golden) begin n_fail++; $display("FAIL restart_sig: got %h want %h", signature, golden); end
        n_chk++; if (pass !== 1'b1)        begin n_fail++; $display("FAIL restart_pass: got %b want 1", pass); end
    endtask

    task automatic test_start_in_run();
        int cnt, nb;
        cnt = 0;
        start_pulse();
        repeat (5) begin
            if (busy === 1'b1) cnt++;
            tick();
        end
        start = 1'b1;
        if (busy === 1'b1) cnt++;
        tick();
        start = 1'b0;
        wait_done(nb);
        n_chk++; if (cnt + nb !== TOTAL)   begin n_fail++; $display("FAIL midstart_len: got %0d want %0d", cnt + nb, TOTAL); end
        n_chk++; if (signature !== golden) begin n_fail++; $display("FAIL midstart_sig: got %h want %h", signature, golden); end
    endtask

    task automatic test_rst_mid_run();
        start_pulse();
        repeat (9) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: busy=%b done=%b want 0/0", busy, done); end
        n_chk++; if (signature !== 64'd0)            begin n_fail++; $display("FAIL rst_mid_sig: got %h want 0", signature); end
        n_chk++; if (porta !== 64'd0)                begin n_fail++; $display("FAIL rst_mid_porta: got %h want 0", porta); end
        n_chk++; if (pass !== 1'b0)                  begin n_fail++; $display("FAIL rst_mid_pass: got %b want 0", pass); end
        tick();
        n_chk++; if (busy !== 1'b0)                  begin n_fail++; $display("FAIL rst_mid_stay: busy=%b want 0", busy); end
    endtask

    task automatic test_random();
        int     nb;
        dword_t rs;
        mode = 3;
        for (int i = 0; i < 3; i++) begin
            key = {$urandom, $urandom} | 64'h1;
            model_run(3, rs);
            expected_sig = rs;
            start_pulse();
            wait_done(nb);
            n_chk++; if (nb !== TOTAL)     begin n_fail++; $display("FAIL rand_len[%0d]: got %0d want %0d", i, nb, TOTAL); end
            n_chk++; if (signature !== rs) begin n_fail++; $display("FAIL rand_sig[%0d]: got %h want %h", i, signature, rs); end
            n_chk++; if (pass !== 1'b1)    begin n_fail++; $display("FAIL rand_pass[%0d]: got %b want 1", i, pass); end
        end
    endtask

    initial begin
        test_reset();
        test_pattern_misr();
        test_length_golden();
        test_pass_fail();
        test_fault();
        test_restart();
        test_start_in_run();
        test_rst_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
